mux_nxw_pipe: RTL and testbench
===============================

// Module: mux_nxw_pipe
// PURPOSE
//  Parametrised N-channel, W-bit pipelined multiplexer with valid/ready handshake.
//  Successor to the single-bit 2:1 combinational mux in the elementary-logic set.
//  sel_in steers one input channel into a registered output stage.
//  A 2-entry skid buffer gives full throughput with registered backpressure.
//  Sits between Hack datapath producers (ALU/RAM/IO) and a single consumer.
// PARAMETERS
//  WIDTH     16                          data word width (Hack word)
//  CHANNELS  4                           number of input channels, >= 2
//  SEL_W     $clog2(CHANNELS)            select width, derived; do not override
// PORTS
//  clk_in      in   1               clock; all state updates on rising edge
//  rst_in      in   1               reset, asynchronous, active-high
//  data_in     in   CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//  valid_in    in   CHANNELS        per-channel data valid
//  ready_out   out  CHANNELS        per-channel ready; at most one bit high
//  sel_in      in   SEL_W           channel select, sampled every cycle
//  y_out       out  WIDTH           output data (head entry)
//  valid_out   out  1               output valid
//  ready_in    in   1               consumer ready
//  occ_out     out  2               entries held (0..2)
//  sel_err_out out  1               pulse: sel_in >= CHANNELS while valid_in[sel] high
// BEHAVIOUR
//  Reset (async, rst_in=1): occupancy 0, valid_out=0, y_out=0, skid data=0,
//   occ_out=0, sel_err_out=0. ready_out forced to all-0 while rst_in is high.
//  Reset deasserted: ready_out[sel_in]=1 on the next cycle.
//  Any stored data is discarded on reset mid-operation. No partial transfer survives.
//  ready_out[i] = !rst_in && (sel_in==i) && (occ != 2). Combinational only in sel_in.
//   The occupancy term is registered.
//  Accept: acc = valid_in[sel_in] && ready_out[sel_in].
//  Drain:  drn = valid_out && ready_in.
//  Sel out of range (CHANNELS not a power of 2, sel_in >= CHANNELS):
//   all ready_out=0, no accept.
//   sel_err_out=1 for one cycle, registered, one cycle after the offending cycle.
//  Occupancy FSM (EMPTY/ONE/TWO), evaluated on each clock edge:
//   EMPTY: acc -> ONE, head<=data. Else stay.
//   ONE:   acc&&drn -> ONE, head<=data.
//          acc&&!drn -> TWO, skid<=data.
//          !acc&&drn -> EMPTY.
//          !acc&&!drn -> stay.
//   TWO:   ready_out all 0, no accept possible.
//          drn -> ONE, head<=skid.
//          !drn -> stay.
//  valid_out=1 in ONE and TWO. occ_out encodes the state as 0/1/2.
//  Latency: accepted word appears on y_out one cycle after acc when EMPTY.
//  Throughput: 1 word/cycle sustained while ready_in=1.
//  Ordering: strict FIFO across channels. sel_in may change every cycle.
//  y_out/valid_out are stable while valid_out && !ready_in (AXI-style hold).
//  y_out holds its last value when valid_out=0.
//  Channels not selected are never acknowledged. Their data is ignored.
//  No X propagation: unselected data_in slices never reach state.
// TESTING
//  T1 reset: rst_in=1 mid-stream (occ=2) -> next edge-independent:
//     valid_out=0, occ_out=0, y_out=0, ready_out=0. Release -> ready_out[sel]=1.
//  T2 streaming: sel_in=2, data 0x0001..0x0010 each cycle, ready_in=1
//     -> y_out sequence identical, 1-cycle latency, occ_out=1 steady.
//  T3 backpressure: ready_in=0 after 2 accepts -> occ_out=2, ready_out=0, y_out holds
//     the first word. ready_in=1 -> words drain in order, no loss, no duplicate.
//  T4 channel switch: sel_in cycles 0,1,2,3 with data 0xA000+i
//     -> output 0xA000,0xA001,0xA002,0xA003 in order.
//     Unselected valid_in never sees ready.
//  T5 bad select (CHANNELS=3): sel_in=3, valid_in=3'b111 -> no accept, ready_out=0,
//     sel_err_out=1 next cycle, occ unchanged.
//  T6 random: random valid_in/ready_in/sel_in, 10k cycles vs scoreboard queue
//     -> zero mismatches. Never more than one ready_out bit high.

Source files
------------

// File: rtl/mux_nxw_pipe.sv
// N-channel, W-bit pipelined multiplexer with valid/ready handshake.
// A two-entry skid buffer keeps full throughput while ready_out stays registered in occupancy.
module mux_nxw_pipe #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]       valid_in,
   output logic [CHANNELS-1:0]       ready_out,
   input  logic [SEL_W-1:0]          sel_in,
   output logic [WIDTH-1:0]          y_out,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic [1:0]                occ_out,
   output logic                      sel_err_out
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occState_t;

   occState_t        r_state;
   occState_t        w_nextState;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_skid;
   logic             r_selErr;

   logic [WIDTH-1:0] w_selData;
   logic             w_selValid;
   logic             w_selInRange;
   logic             w_full;
   logic             w_acc;
   logic             w_drn;

   // Only the selected slice is ever forwarded, so unselected data cannot reach state.
   always_comb begin
      w_selData    = '0;
      w_selValid   = 1'b0;
      w_selInRange = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel_in == SEL_W'(i)) begin
            w_selData    = data_in[i*WIDTH +: WIDTH];
            w_selValid   = valid_in[i];
            w_selInRange = 1'b1;
         end
      end
   end

   always_comb begin
      ready_out = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ready_out[i] = !rst_in && !w_full && (sel_in == SEL_W'(i));
      end
   end

   assign w_acc = w_selValid && w_selInRange && !w_full && !rst_in;
   assign w_drn = valid_out && ready_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         EMPTY: begin
            if (w_acc) begin
               w_nextState = ONE;
            end
         end
         ONE: begin
            if (w_acc && !w_drn) begin
               w_nextState = TWO;
            end else if (!w_acc && w_drn) begin
               w_nextState = EMPTY;
            end
         end
         TWO: begin
            if (w_drn) begin
               w_nextState = ONE;
            end
         end
         default: begin
            w_nextState = EMPTY;
         end
      endcase
   end

   always_comb begin
      valid_out = (r_state != EMPTY);
      w_full    = (r_state == TWO);
      occ_out   = r_state;
   end

   // Head is the word on y_out; skid only fills when the head is stalled.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_acc) begin
                  r_head <= w_selData;
               end
            end
            ONE: begin
               if (w_acc && w_drn) begin
                  r_head <= w_selData;
               end else if (w_acc) begin
                  r_skid <= w_selData;
               end
            end
            TWO: begin
               if (w_drn) begin
                  r_head <= r_skid;
               end
            end
            default: begin
               r_head <= r_head;
            end
         endcase
      end
   end

   // Flags a producer driving valid while the select points past the last channel.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_selErr <= 1'b0;
      end else begin
         r_selErr <= !w_selInRange && (|valid_in);
      end
   end

   assign y_out       = r_head;
   assign sel_err_out = r_selErr;

endmodule

// File: tb/tb_mux_nxw_pipe.sv
// Scoreboard bench for mux_nxw_pipe: a 4-channel instance under directed and random traffic,
// plus a 3-channel instance for out-of-range select handling.
module tb_mux_nxw_pipe;

   logic        clkIn;
   logic        rstIn;
   logic [63:0] dataIn;
   logic [3:0]  validIn;
   logic [3:0]  readyOut;
   logic [1:0]  selIn;
   logic [15:0] yOut;
   logic        validOut;
   logic        readyIn;
   logic [1:0]  occOut;
   logic        selErrOut;

   logic        rst3;
   logic [47:0] data3;
   logic [2:0]  valid3;
   logic [2:0]  ready3Out;
   logic [1:0]  sel3;
   logic [15:0] y3;
   logic        validOut3;
   logic        readyIn3;
   logic [1:0]  occ3;
   logic        selErr3;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sbQueue[$];
   logic [15:0] lastY = 16'h0000;

   mux_nxw_pipe #(.WIDTH(16), .CHANNELS(4)) dut (
      .clk_in(clkIn), .rst_in(rstIn), .data_in(dataIn), .valid_in(validIn),
      .ready_out(readyOut), .sel_in(selIn), .y_out(yOut), .valid_out(validOut),
      .ready_in(readyIn), .occ_out(occOut), .sel_err_out(selErrOut)
   );

   mux_nxw_pipe #(.WIDTH(16), .CHANNELS(3)) dut3 (
      .clk_in(clkIn), .rst_in(rst3), .data_in(data3), .valid_in(valid3),
      .ready_out(ready3Out), .sel_in(sel3), .y_out(y3), .valid_out(validOut3),
      .ready_in(readyIn3), .occ_out(occ3), .sel_err_out(selErr3)
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic [3:0] valid,
                                input logic [63:0] data, input logic ready);
      @(posedge clkIn);
      #1;
      selIn   = sel;
      validIn = valid;
      dataIn  = data;
      readyIn = ready;
   endtask

   function automatic logic [63:0] pack4(input logic [15:0] d0, input logic [15:0] d1,
                                         input logic [15:0] d2, input logic [15:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   // Model occupancy is the scoreboard depth; checks run mid-cycle, then the model steps.
   always @(negedge clkIn) begin : monitor
      int          sz;
      logic [3:0]  expReady;
      logic        acc;
      if (!rstIn) begin
         sz       = sbQueue.size();
         expReady = (sz == 2) ? 4'b0000 : (4'b0001 << selIn);
         checkOutput("occ", 32'(occOut), 32'(sz));
         checkOutput("validOut", 32'(validOut), 32'(sz != 0));
         checkOutput("readyOut", 32'(readyOut), 32'(expReady));
         checkOutput("selErr", 32'(selErrOut), 32'd0);
         if (sz != 0) begin
            checkOutput("yHead", 32'(yOut), 32'(sbQueue[0]));
         end else begin
            checkOutput("yHold", 32'(yOut), 32'(lastY));
         end
         acc = validIn[selIn] && (sz != 2);
         if (sz != 0 && readyIn) begin
            lastY = sbQueue.pop_front();
         end
         if (acc) begin
            sbQueue.push_back(dataIn[int'(selIn)*16 +: 16]);
         end
      end
   end

   initial begin
      rstIn   = 1'b1;
      dataIn  = '0;
      validIn = '0;
      selIn   = 2'd0;
      readyIn = 1'b0;
      rst3    = 1'b1;
      data3   = '0;
      valid3  = '0;
      sel3    = 2'd0;
      readyIn3 = 1'b0;

      #2;
      checkOutput("rstOcc", 32'(occOut), 32'd0);
      checkOutput("rstValid", 32'(validOut), 32'd0);
      checkOutput("rstY", 32'(yOut), 32'd0);
      checkOutput("rstReady", 32'(readyOut), 32'd0);
      checkOutput("rstSelErr", 32'(selErrOut), 32'd0);
      repeat (3) @(posedge clkIn);
      #1;
      rstIn = 1'b0;
      selIn = 2'd2;

      // Streaming on channel 2 at one word per cycle.
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(2'd2, 4'b0100, pack4(16'hFFFF, 16'hEEEE, 16'(i), 16'hDDDD), 1'b1);
      end
      repeat (3) applyStimulus(2'd2, 4'b0000, '0, 1'b1);

      // Backpressure: two words fill the buffer, a third waits for space.
      applyStimulus(2'd0, 4'b0001, pack4(16'h0100, 16'h0, 16'h0, 16'h0), 1'b0);
      applyStimulus(2'd0, 4'b0001, pack4(16'h0101, 16'h0, 16'h0, 16'h0), 1'b0);
      repeat (3) applyStimulus(2'd0, 4'b0001, pack4(16'h0102, 16'h0, 16'h0, 16'h0), 1'b0);
      applyStimulus(2'd0, 4'b0001, pack4(16'h0102, 16'h0, 16'h0, 16'h0), 1'b1);
      repeat (4) applyStimulus(2'd0, 4'b0000, '0, 1'b1);

      // Reset while full: everything clears asynchronously.
      applyStimulus(2'd1, 4'b0010, pack4(16'h0, 16'h0200, 16'h0, 16'h0), 1'b0);
      repeat (3) applyStimulus(2'd1, 4'b0010, pack4(16'h0, 16'h0201, 16'h0, 16'h0), 1'b0);
      #2;
      rstIn   = 1'b1;
      validIn = 4'b0000;
      #1;
      checkOutput("midRstOcc", 32'(occOut), 32'd0);
      checkOutput("midRstValid", 32'(validOut), 32'd0);
      checkOutput("midRstY", 32'(yOut), 32'd0);
      checkOutput("midRstReady", 32'(readyOut), 32'd0);
      sbQueue.delete();
      lastY = 16'h0000;
      @(posedge clkIn);
      #1;
      rstIn = 1'b0;
      applyStimulus(2'd1, 4'b0000, '0, 1'b1);

      // Channel switch with every channel valid; only the selected one may be taken.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'(i), 4'b1111,
                       pack4((i == 0) ? 16'hA000 : 16'hB000, (i == 1) ? 16'hA001 : 16'hB001,
                             (i == 2) ? 16'hA002 : 16'hB002, (i == 3) ? 16'hA003 : 16'hB003),
                       1'b1);
      end
      repeat (3) applyStimulus(2'd0, 4'b0000, '0, 1'b1);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         logic [3:0]  v;
         logic [63:0] d;
         v = 4'($urandom);
         d = {$urandom, $urandom};
         applyStimulus(2'($urandom_range(0, 3)), v, d, 1'($urandom_range(0, 1)));
      end
      repeat (4) applyStimulus(2'd0, 4'b0000, '0, 1'b1);

      // Three-channel instance: select 3 is out of range.
      @(posedge clkIn);
      #1;
      rst3   = 1'b0;
      sel3   = 2'd3;
      valid3 = 3'b111;
      data3  = {16'h3333, 16'h2222, 16'h1111};
      @(negedge clkIn);
      checkOutput("badSelReady", 32'(ready3Out), 32'd0);
      checkOutput("badSelOcc", 32'(occ3), 32'd0);
      checkOutput("badSelErrEarly", 32'(selErr3), 32'd0);
      @(posedge clkIn);
      #1;
      sel3   = 2'd0;
      valid3 = 3'b001;
      @(negedge clkIn);
      checkOutput("badSelErrPulse", 32'(selErr3), 32'd1);
      checkOutput("goodSelReady", 32'(ready3Out), 32'd1);
      checkOutput("noAcceptOcc", 32'(occ3), 32'd0);
      @(posedge clkIn);
      #1;
      sel3   = 2'd3;
      valid3 = 3'b111;
      @(negedge clkIn);
      checkOutput("errCleared", 32'(selErr3), 32'd0);
      checkOutput("acceptOcc", 32'(occ3), 32'd1);
      checkOutput("acceptY", 32'(y3), 32'h1111);
      checkOutput("acceptValid", 32'(validOut3), 32'd1);
      checkOutput("badSelReady2", 32'(ready3Out), 32'd0);
      @(posedge clkIn);
      #1;
      sel3   = 2'd1;
      valid3 = 3'b000;
      @(negedge clkIn);
      checkOutput("badSelErrPulse2", 32'(selErr3), 32'd1);
      checkOutput("occUnchanged", 32'(occ3), 32'd1);
      @(negedge clkIn);
      checkOutput("errCleared2", 32'(selErr3), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
